dbus_arbiter: RTL

- Shares one data-memory port between two bus masters.
  - Master 0: the CPU dbus.
  - Master 1: a DMA-style requester, e.g. the display frame fetcher.
- Round-robin arbitration with a bounded burst hold.
- Tags outstanding reads in order and routes read responses back to the master that issued them.
- Sits in main between the cpu dbus / peripheral masters and the shared BRAM/MMIO decoder.

---
 rtl/dbus_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: round-robin grant with bounded bursts, in-order read tagging.
// Optional DBUS_ARB_PERF_EN adds beat/stall performance counters.
module dbus_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int BURST_MAX       = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter bit RESP_EMPTY_ERR  = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              m0_cmd_valid_i,
    output logic              m0_cmd_ready_o,
    input  logic [ADDR_W-1:0] m0_cmd_addr_i,
    input  logic              m0_cmd_we_i,
    input  logic [31:0]       m0_wdata_data_i,
    input  logic [3:0]        m0_wdata_strb_i,
    output logic              m0_rdata_valid_o,
    output logic [31:0]       m0_rdata_data_o,

    input  logic              m1_cmd_valid_i,
    output logic              m1_cmd_ready_o,
    input  logic [ADDR_W-1:0] m1_cmd_addr_i,
    input  logic              m1_cmd_we_i,
    input  logic [31:0]       m1_wdata_data_i,
    input  logic [3:0]        m1_wdata_strb_i,
    output logic              m1_rdata_valid_o,
    output logic [31:0]       m1_rdata_data_o,

    output logic              s_cmd_valid_o,
    input  logic              s_cmd_ready_i,
    output logic [ADDR_W-1:0] s_cmd_addr_o,
    output logic              s_cmd_we_o,
    output logic [31:0]       s_wdata_data_o,
    output logic [3:0]        s_wdata_strb_o,
    input  logic              s_rdata_valid_i,
    input  logic [31:0]       s_rdata_data_i
`ifdef DBUS_ARB_PERF_EN
    ,
    output logic [31:0]       perf_grant0_o,
    output logic [31:0]       perf_grant1_o,
    output logic [31:0]       perf_stall_o
`endif
);

    // state | meaning
    // IDLE  | no owner, arbitrating; nothing forwarded
    // OWN0  | master 0 owns the slave port
    // OWN1  | master 1 owns the slave port
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(BURST_MAX) + 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

    state_t           state, state_nxt;
    logic             last_r;
    logic [CNT_W-1:0] burst_cnt;

    logic             tag_mem [MAX_OUTSTANDING];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             tag_full, tag_empty, tag_head;

    logic             own_valid, own_we;
    logic             accept, push, pop, release_own;

    assign tag_empty = (wr_ptr == rd_ptr);
    assign tag_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign tag_head  = tag_mem[rd_ptr[PTR_W-1:0]];

    always_comb begin
        s_cmd_valid_o  = 1'b0;
        s_cmd_addr_o   = '0;
        s_cmd_we_o     = 1'b0;
        s_wdata_data_o = '0;
        s_wdata_strb_o = '0;
        own_valid      = 1'b0;
        own_we         = 1'b0;
        state_nxt      = state;

        case (state)
            OWN0: begin
                own_valid      = m0_cmd_valid_i;
                own_we         = m0_cmd_we_i;
                s_cmd_addr_o   = m0_cmd_addr_i;
                s_cmd_we_o     = m0_cmd_we_i;
                s_wdata_data_o = m0_wdata_data_i;
                s_wdata_strb_o = m0_wdata_strb_i;
            end
            OWN1: begin
                own_valid      = m1_cmd_valid_i;
                own_we         = m1_cmd_we_i;
                s_cmd_addr_o   = m1_cmd_addr_i;
                s_cmd_we_o     = m1_cmd_we_i;
                s_wdata_data_o = m1_wdata_data_i;
                s_wdata_strb_o = m1_wdata_strb_i;
            end
            default: ;
        endcase

        // Reads need a free tag slot; writes never wait on the FIFO.
        s_cmd_valid_o = own_valid & ~(~own_we & tag_full);
        accept        = s_cmd_valid_o & s_cmd_ready_i;
        push          = accept & ~own_we;
        release_own   = (state != IDLE) &
                        (~own_valid | (accept & (burst_cnt == BURST_LAST)));

        case (state)
            IDLE: begin
                if (m0_cmd_valid_i && m1_cmd_valid_i)
                    state_nxt = last_r ? OWN0 : OWN1;
                else if (m0_cmd_valid_i)
                    state_nxt = OWN0;
                else if (m1_cmd_valid_i)
                    state_nxt = OWN1;
            end
            OWN0: if (release_own) state_nxt = m1_cmd_valid_i ? OWN1 : IDLE;
            OWN1: if (release_own) state_nxt = m0_cmd_valid_i ? OWN0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign m0_cmd_ready_o = (state == OWN0) & accept;
    assign m1_cmd_ready_o = (state == OWN1) & accept;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            last_r    <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (release_own) begin
                last_r    <= (state == OWN1);
                burst_cnt <= '0;
            end else if (accept) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

    // Responses with no outstanding tag are dropped.
    assign pop              = s_rdata_valid_i & ~tag_empty;
    assign m0_rdata_valid_o = pop & ~tag_head;
    assign m1_rdata_valid_o = pop & tag_head;
    assign m0_rdata_data_o  = s_rdata_data_i;
    assign m1_rdata_data_o  = s_rdata_data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) tag_mem[wr_ptr[PTR_W-1:0]] <= (state == OWN1);
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (RESP_EMPTY_ERR && rst_ni && s_rdata_valid_i && tag_empty)
            $error("dbus_arbiter: read response with no outstanding tag");
    end
`endif

`ifdef DBUS_ARB_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_grant0_o <= '0;
            perf_grant1_o <= '0;
            perf_stall_o  <= '0;
        end else begin
            if (m0_cmd_ready_o) perf_grant0_o <= perf_grant0_o + 32'd1;
            if (m1_cmd_ready_o) perf_grant1_o <= perf_grant1_o + 32'd1;
            if ((m0_cmd_valid_i & ~m0_cmd_ready_o) | (m1_cmd_valid_i & ~m1_cmd_ready_o))
                perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule
